// File: rtl/alu_mul_seq_if.sv
// Processor request/response and shared-ALU signals of the sequential multiplier.
// The master side is the environment (processor plus ALU); the slave side is the controller.
interface alu_mul_seq_if #(
   parameter int unsigned W = 8
);
   logic         Start;
   logic [W-1:0] OpA;
   logic [W-1:0] OpB;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Product;
   logic         Ovf;
   logic [W-1:0] AluA;
   logic [W-1:0] AluB;
   logic [3:0]   AluOp;
   logic         AluSC;
   logic [W-1:0] AluOut;
   logic         AluZero;

   modport master (
      output Start, OpA, OpB,
      input  Busy, Done, Product, Ovf,
      input  AluA, AluB, AluOp, AluSC,
      output AluOut, AluZero
   );

   modport slave (
      input  Start, OpA, OpB,
      output Busy, Done, Product, Ovf,
      output AluA, AluB, AluOp, AluSC,
      input  AluOut, AluZero
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned WxW multiply (low W bits plus overflow flag) by sequencing a shared ALU
// through shift-and-add; one ALU operation per cycle.
module alu_mul_seq #(
   parameter int unsigned W = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   alu_mul_seq_if.slave bus
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_LSL = 4'b0001;
   localparam logic [3:0] OP_LSR = 4'b0010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHK,
      S_ADD,
      S_SHL,
      S_SHR,
      S_DONE
   } state_e;

   state_e       state_q, state_d;
   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] mc_q, mc_d;
   logic [W-1:0] mp_q, mp_d;
   logic         ovf_acc_q, ovf_acc_d;
   logic [W-1:0] product_q, product_d;
   logic         ovf_q, ovf_d;
   logic [W-1:0] alu_a, alu_b;
   logic [3:0]   alu_op;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mc_q      <= '0;
         mp_q      <= '0;
         ovf_acc_q <= 1'b0;
         product_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mc_q      <= mc_d;
         mp_q      <= mp_d;
         ovf_acc_q <= ovf_acc_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mc_d      = mc_q;
      mp_d      = mp_q;
      ovf_acc_d = ovf_acc_q;
      product_d = product_q;
      ovf_d     = ovf_q;
      alu_op    = OP_ADD;
      alu_a     = '0;
      alu_b     = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               acc_d     = '0;
               mc_d      = bus.OpA;
               mp_d      = bus.OpB;
               ovf_acc_d = 1'b0;
               state_d   = S_CHK;
            end
         end
         S_CHK: begin
            if (mp_q == '0)  state_d = S_DONE;
            else if (mp_q[0]) state_d = S_ADD;
            else              state_d = S_SHL;
         end
         S_ADD: begin
            alu_a     = acc_q;
            alu_b     = mc_q;
            acc_d     = bus.AluOut;
            ovf_acc_d = ovf_acc_q | (bus.AluOut < acc_q);
            state_d   = S_SHL;
         end
         S_SHL: begin
            alu_op    = OP_LSL;
            alu_a     = mc_q;
            mc_d      = bus.AluOut;
            // A multiplicand bit shifted out only matters if a higher multiplier bit remains.
            ovf_acc_d = ovf_acc_q | (mc_q[W-1] & (|(mp_q >> 1)));
            state_d   = S_SHR;
         end
         S_SHR: begin
            alu_op  = OP_LSR;
            alu_a   = mp_q;
            mp_d    = bus.AluOut;
            state_d = bus.AluZero ? S_DONE : S_CHK;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_DONE) begin
         product_d = acc_d;
         ovf_d     = ovf_acc_d;
      end
   end

   assign bus.Busy    = (state_q == S_CHK) || (state_q == S_ADD) ||
                        (state_q == S_SHL) || (state_q == S_SHR);
   assign bus.Done    = (state_q == S_DONE);
   assign bus.Product = product_q;
   assign bus.Ovf     = ovf_q;
   assign bus.AluA    = alu_a;
   assign bus.AluB    = alu_b;
   assign bus.AluOp   = alu_op;
   assign bus.AluSC   = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU attached and a per-cycle
// model of the expected ALU trace, status and result registers.
module tb_alu_mul_seq;

   localparam int unsigned W = 8;

   typedef struct {
      logic       busy;
      logic       done;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] prod;
      logic       ovf;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;
   alu_mul_seq_if #(.W(W)) bus ();

   alu_mul_seq #(.W(W)) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;

   always_comb begin
      case (bus.AluOp)
         4'b0000: bus.AluOut = bus.AluA + bus.AluB;
         4'b0001: bus.AluOut = {bus.AluA[W-2:0], bus.AluSC};
         4'b0010: bus.AluOut = bus.AluA >> 1;
         default: bus.AluOut = '0;
      endcase
      bus.AluZero = (bus.AluOut == '0);
   end

   int         vectors = 0;
   int         miscompares = 0;
   exp_t       exp_q[$];
   logic [7:0] held_prod = 8'h00;
   logic       held_ovf = 1'b0;
   logic [3:0] ops [0:63];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic void push_e(input logic busy, input logic done, input logic [3:0] op,
                                  input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.busy = busy; e.done = done; e.op = op; e.a = a; e.b = b;
      e.prod = held_prod; e.ovf = held_ovf;
      exp_q.push_back(e);
   endfunction

   // Expected cycle-by-cycle trace from the shift-and-add definition over multiplier bits.
   function automatic void push_op(input logic [7:0] a, input logic [7:0] b);
      int unsigned full;
      int          h;
      full = 32'(a) * 32'(b);
      if (b == 8'h00) begin
         push_e(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
      end else begin
         h = 0;
         for (int i = 0; i < 8; i++) if (b[i]) h = i;
         for (int i = 0; i <= h; i++) begin
            logic [7:0] acc, mc, mp;
            acc = 8'(32'(a) * (32'(b) & ((32'd1 << i) - 32'd1)));
            mc  = 8'(32'(a) << i);
            mp  = b >> i;
            push_e(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
            if (b[i]) push_e(1'b1, 1'b0, 4'd0, acc, mc);
            push_e(1'b1, 1'b0, 4'd1, mc, 8'h00);
            push_e(1'b1, 1'b0, 4'd2, mp, 8'h00);
         end
      end
      held_prod = full[7:0];
      held_ovf  = (full >= 32'd256);
      push_e(1'b0, 1'b1, 4'd0, 8'h00, 8'h00);
   endfunction

   always @(negedge Clk) begin
      exp_t e;
      if (!Reset) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
         end else begin
            e.busy = 1'b0; e.done = 1'b0; e.op = 4'd0; e.a = 8'h00; e.b = 8'h00;
            e.prod = held_prod; e.ovf = held_ovf;
         end
         chk("Busy",    32'(bus.Busy),    32'(e.busy));
         chk("Done",    32'(bus.Done),    32'(e.done));
         chk("AluOp",   32'(bus.AluOp),   32'(e.op));
         chk("AluA",    32'(bus.AluA),    32'(e.a));
         chk("AluB",    32'(bus.AluB),    32'(e.b));
         chk("AluSC",   32'(bus.AluSC),   32'd0);
         chk("Product", 32'(bus.Product), 32'(e.prod));
         chk("Ovf",     32'(bus.Ovf),     32'(e.ovf));
      end
   end

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int lat,
                         input logic [7:0] prod, input logic ovf, input int pulse,
                         input string name);
      int cyc;
      bit seen;
      @(negedge Clk);
      #1;
      bus.Start = 1'b1; bus.OpA = a; bus.OpB = b;
      push_op(a, b);
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(negedge Clk);
         cyc++;
         if (cyc < 64) ops[cyc] = bus.AluOp;
         if (bus.Done) seen = 1'b1;
         else begin
            #1;
            bus.Start = (cyc == pulse);
            if (cyc == pulse) begin
               bus.OpA = ~a; bus.OpB = 8'hFF;
            end
         end
      end
      chk({name, " latency"}, 32'(cyc), 32'(lat));
      chk({name, " Product"}, 32'(bus.Product), 32'(prod));
      chk({name, " Ovf"}, 32'(bus.Ovf), 32'(ovf));
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, " Busy"},    32'(bus.Busy),    32'd0);
      chk({name, " Done"},    32'(bus.Done),    32'd0);
      chk({name, " Product"}, 32'(bus.Product), 32'd0);
      chk({name, " Ovf"},     32'(bus.Ovf),     32'd0);
      chk({name, " AluOp"},   32'(bus.AluOp),   32'd0);
   endtask

   initial begin
      int tr [10] = '{0, 1, 2, 0, 1, 2, 0, 0, 1, 2};
      Reset = 1'b1;
      bus.Start = 1'b0; bus.OpA = 8'h00; bus.OpB = 8'h00;
      #12;
      chk_reset_state("reset");
      @(negedge Clk);
      #1 Reset = 1'b0;

      run_op(8'd3, 8'd5, 12, 8'h0F, 1'b0, -1, "3x5");
      for (int i = 2; i <= 11; i++) chk("3x5 op trace", 32'(ops[i]), 32'(tr[i-2]));
      run_op(8'hFF, 8'h00, 2, 8'h00, 1'b0, -1, "FFx0");
      run_op(8'd16, 8'd16, 17, 8'h00, 1'b1, -1, "16x16");
      run_op(8'd255, 8'd255, 33, 8'h01, 1'b1, -1, "255x255");
      run_op(8'd20, 8'd12, 15, 8'hF0, 1'b0, 3, "20x12");

      // Start held high across two back-to-back operations, with a stray pulse mid-run.
      @(negedge Clk);
      #1;
      bus.Start = 1'b1; bus.OpA = 8'd7; bus.OpB = 8'd2;
      push_op(8'd7, 8'd2);
      push_e(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      push_op(8'd2, 8'd7);
      @(negedge Clk);
      #1;
      bus.OpA = 8'd2; bus.OpB = 8'd7;
      for (int c = 2; c <= 22; c++) begin
         @(negedge Clk);
         if (c == 8) begin
            chk("7x2 Done", 32'(bus.Done), 32'd1);
            chk("7x2 Product", 32'(bus.Product), 32'h0E);
         end
         if (c == 9) begin
            chk("gap Busy", 32'(bus.Busy), 32'd0);
            chk("gap Done", 32'(bus.Done), 32'd0);
            chk("gap Product", 32'(bus.Product), 32'h0E);
         end
         if (c == 10) #1 bus.Start = 1'b0;
         if (c == 14) #1 bus.Start = 1'b1;
         if (c == 15) #1 bus.Start = 1'b0;
         if (c == 22) begin
            chk("2x7 Done", 32'(bus.Done), 32'd1);
            chk("2x7 Product", 32'(bus.Product), 32'h0E);
            chk("2x7 Ovf", 32'(bus.Ovf), 32'd0);
         end
      end

      // Asynchronous reset during cycle 4 of 3x5.
      @(negedge Clk);
      #1;
      bus.Start = 1'b1; bus.OpA = 8'd3; bus.OpB = 8'd5;
      push_op(8'd3, 8'd5);
      @(negedge Clk);
      #1 bus.Start = 1'b0;
      repeat (3) @(negedge Clk);
      #1 Reset = 1'b1;
      exp_q.delete();
      held_prod = 8'h00;
      held_ovf  = 1'b0;
      #1;
      chk_reset_state("mid-run reset");
      @(negedge Clk);
      #1 Reset = 1'b0;

      run_op(8'd3, 8'd5, 12, 8'h0F, 1'b0, -1, "3x5 after reset");
      repeat (3) @(negedge Clk);
      chk("expected queue drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
